store_narrow_unit: RTL

Store-side counterpart of the load-path sign/zero extender. Takes a 32-bit register value plus an access size and byte address, narrows it to byte, halfword or word, and places it on the correct byte lanes of the 32-bit data-memory word. Checks alignment and then drives a single write transaction to data memory with a request/acknowledge handshake. Sits between the CPU's store datapath and the data memory port.

---
 rtl/store_narrow_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: places a byte/halfword/word on the right byte lanes of a
// 32-bit data-memory word, rejects misaligned stores and runs one handshaked write.
// Optional STORE_TIMEOUT_EN adds a bounded wait for MemAck and a Timeout flag.
module store_narrow_unit #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        store_size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       write_data_i,
    input  logic              mem_ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              addr_err_o,
`ifdef STORE_TIMEOUT_EN
    output logic              timeout_o,
`endif
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_byte_en_o,
    output logic [31:0]       mem_data_o
);

    // The ack-wait counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("store_narrow_unit: TIMEOUT_CYC must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic              addr_err_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_byte_en_q;
    logic [31:0]       mem_data_q;

    logic              misaligned_d;
    logic [3:0]        byte_en_d;
    logic [31:0]       data_d;
    logic [ADDR_W-1:0] word_addr_d;

`ifdef STORE_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
    logic       timeout_q;
    logic [7:0] wait_cnt_q;
`endif

    // Lane placement and alignment are decoded straight from the request so the
    // narrowed word is what gets captured on the accepting edge.
    always_comb begin
        misaligned_d = 1'b0;
        byte_en_d    = 4'b0000;
        data_d       = 32'h0000_0000;
        word_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
        case (store_size_i)
            2'b00: begin
                byte_en_d = 4'b0001 << addr_i[1:0];
                data_d    = {4{write_data_i[7:0]}};
            end
            2'b01: begin
                misaligned_d = addr_i[0];
                byte_en_d    = addr_i[1] ? 4'b1100 : 4'b0011;
                data_d       = {2{write_data_i[15:0]}};
            end
            2'b10: begin
                misaligned_d = |addr_i[1:0];
                byte_en_d    = 4'b1111;
                data_d       = write_data_i;
            end
            default: begin
                misaligned_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            addr_err_q    <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_byte_en_q <= 4'b0000;
            mem_data_q    <= 32'h0000_0000;
`ifdef STORE_TIMEOUT_EN
            timeout_q     <= 1'b0;
            wait_cnt_q    <= 8'd0;
`endif
        end else begin
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
`ifdef STORE_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        busy_q     <= 1'b1;
                        mem_addr_q <= word_addr_d;
                        if (misaligned_d) begin
                            state_q       <= ST_ERR;
                            done_q        <= 1'b1;
                            addr_err_q    <= 1'b1;
                            mem_byte_en_q <= 4'b0000;
                            mem_data_q    <= 32'h0000_0000;
                        end else begin
                            state_q       <= ST_REQ;
                            mem_wr_q      <= 1'b1;
                            mem_byte_en_q <= byte_en_d;
                            mem_data_q    <= data_d;
`ifdef STORE_TIMEOUT_EN
                            wait_cnt_q    <= 8'd0;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over an expiring wait in the same cycle.
                    if (mem_ack_i) begin
                        state_q  <= ST_DONE;
                        mem_wr_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
`ifdef STORE_TIMEOUT_EN
                    else if (wait_cnt_q == TMO_LAST) begin
                        state_q   <= ST_DONE;
                        mem_wr_q  <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
`endif
                end
                ST_DONE, ST_ERR: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign addr_err_o    = addr_err_q;
    assign mem_wr_o      = mem_wr_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_byte_en_o = mem_byte_en_q;
    assign mem_data_o    = mem_data_q;
`ifdef STORE_TIMEOUT_EN
    assign timeout_o     = timeout_q;
`endif

endmodule
